// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the column-serial MixColumns engine.
package aes_pkg;

   typedef enum logic [1:0] {
      CIPH_FWD = 2'b01,
      CIPH_INV = 2'b10
   } ciph_op_e;

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      CALC  = 4'b0010,
      CHECK = 4'b0100,
      DONE  = 4'b1000
   } aes_mix_fsm_e;

   function automatic logic [7:0] aes_mul2(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] aes_mul4(input logic [7:0] a);
      return aes_mul2(aes_mul2(a));
   endfunction

   function automatic logic aes_op_ok(input ciph_op_e op);
      return (op == CIPH_FWD) || (op == CIPH_INV);
   endfunction

   // 2a^3b^c^d rewritten as all^a^2(a^b)
   function automatic logic [3:0][7:0] aes_mix_fwd(input logic [3:0][7:0] a);
      logic [7:0]       all;
      logic [3:0][7:0]  y;
      all  = a[0] ^ a[1] ^ a[2] ^ a[3];
      y[0] = all ^ a[0] ^ aes_mul2(a[0] ^ a[1]);
      y[1] = all ^ a[1] ^ aes_mul2(a[1] ^ a[2]);
      y[2] = all ^ a[2] ^ aes_mul2(a[2] ^ a[3]);
      y[3] = all ^ a[3] ^ aes_mul2(a[3] ^ a[0]);
      return y;
   endfunction

endpackage

// File: rtl/aes_mix_col_lane.sv
// Single combinational MixColumns/InvMixColumns column lane.
module aes_mix_col_lane
   import aes_pkg::*;
(
   input  ciph_op_e         op,
   input  logic [3:0][7:0]  a,
   output logic [3:0][7:0]  y
);

   logic [7:0]       u;
   logic [7:0]       v;
   logic [3:0][7:0]  pre;

   // InvMixColumns = MixColumns after folding in 4(a^c), 4(b^d)
   always_comb begin
      u   = aes_mul4(a[0] ^ a[2]);
      v   = aes_mul4(a[1] ^ a[3]);
      pre = {a[3] ^ v, a[2] ^ u, a[1] ^ v, a[0] ^ u};
      y   = '0;
      case (op)
         CIPH_FWD: y = aes_mix_fwd(a);
         CIPH_INV: y = aes_mix_fwd(pre);
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/aes_mix_columns_serial.sv
// Column-serial MixColumns engine with valid/ready in and out.
// Define AES_MIX_SELF_CHECK_EN to add the inverse-direction self-check pass.
module aes_mix_columns_serial
   import aes_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  ciph_op_e              op_i,
   input  logic [3:0][3:0][7:0]  data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [3:0][3:0][7:0]  data_o,
   output logic                  op_err_o,
   output logic                  chk_err_o
);

   aes_mix_fsm_e          state;
   aes_mix_fsm_e          state_nxt;
   logic [1:0]            col;
   logic [3:0][3:0][7:0]  work;
   ciph_op_e              op_q;
   logic                  op_err;
   ciph_op_e              lane_op;
   logic [3:0][7:0]       lane_in;
   logic [3:0][7:0]       lane_out;
   logic                  accept;

   assign accept      = in_valid_i && (state == IDLE);
   assign in_ready_o  = (state == IDLE);
   assign out_valid_o = (state == DONE);
   assign data_o      = work;
   assign op_err_o    = op_err;

   always_comb begin
      lane_op = op_q;
      if (state == CHECK)
         lane_op = (op_q == CIPH_FWD) ? CIPH_INV : CIPH_FWD;
      for (int r = 0; r < 4; r++)
         lane_in[r] = work[r][col];
   end

   aes_mix_col_lane u_lane (
      .op (lane_op),
      .a  (lane_in),
      .y  (lane_out)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (in_valid_i) state_nxt = CALC;
         CALC: begin
            if (col == 2'd3) begin
               state_nxt = DONE;
`ifdef AES_MIX_SELF_CHECK_EN
               if (aes_op_ok(op_q)) state_nxt = CHECK;
`endif
            end
         end
         CHECK: if (col == 2'd3) state_nxt = DONE;
         DONE:  if (out_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         col    <= '0;
         work   <= '0;
         op_q   <= CIPH_FWD;
         op_err <= 1'b0;
      end else if (accept) begin
         col    <= '0;
         work   <= data_i;
         op_q   <= op_i;
         op_err <= !aes_op_ok(op_i);
      end else if (state == CALC) begin
         for (int r = 0; r < 4; r++)
            work[r][col] <= lane_out[r];
         col <= col + 2'd1;
      end else if (state == CHECK) begin
         col <= col + 2'd1;
      end
   end

`ifdef AES_MIX_SELF_CHECK_EN
   logic [3:0][3:0][7:0]  copy;
   logic [3:0][7:0]       copy_col;
   logic                  chk_flag;

   always_comb begin
      for (int r = 0; r < 4; r++)
         copy_col[r] = copy[r][col];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         copy     <= '0;
         chk_flag <= 1'b0;
      end else if (accept) begin
         copy     <= data_i;
         chk_flag <= 1'b0;
      end else if (state == CHECK) begin
         chk_flag <= chk_flag | (lane_out != copy_col);
      end
   end

   assign chk_err_o = chk_flag;
`else
   assign chk_err_o = 1'b0;
`endif

endmodule
